// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address and fills the F/D register.
// Define FETCH_PERF_CNT_EN to add the fetch/stall performance counters.
module fetch_ctrl #(
    parameter logic [31:0] PC_INIT  = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 4096
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_instr_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_instr_o,
    output logic        if_valid_o,
    output logic        fetch_fault_o,
    output logic [1:0]  state_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FAULT = 2'd2
    } state_e;

    // One past the last legal byte address, kept 33 bits wide so the bound never wraps.
    localparam logic [32:0] PC_END = {1'b0, PC_INIT} + {IM_WORDS[30:0], 2'b00};

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        if_valid_q, if_valid_d;
    logic        legal;

    assign legal = (pc_q[1:0] == 2'b00) && (pc_q >= PC_INIT) && ({1'b0, pc_q} < PC_END);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;

        if (stall_i) begin
            state_d = (state_q == FAULT) ? FAULT : STALL;
        end else begin
            if_pc_d = pc_q;
            if (flush_i || !legal) begin
                if_instr_d = 32'h0;
                if_valid_d = 1'b0;
            end else begin
                if_instr_d = im_instr_i;
                if_valid_d = 1'b1;
            end

            // An illegal PC never advances on its own; only a redirect moves it.
            if (state_q == FAULT) begin
                if (redirect_valid_i) begin
                    pc_d    = redirect_target_i;
                    state_d = RUN;
                end
            end else if (!legal) begin
                state_d = FAULT;
                if (redirect_valid_i) begin
                    pc_d = redirect_target_i;
                end
            end else begin
                state_d = RUN;
                pc_d    = redirect_valid_i ? redirect_target_i : pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= RUN;
            pc_q       <= PC_INIT;
            if_pc_q    <= PC_INIT;
            if_instr_q <= 32'h0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign im_addr_o     = pc_q;
    assign if_pc_o       = if_pc_q;
    assign if_instr_o    = if_instr_q;
    assign if_valid_o    = if_valid_q;
    assign fetch_fault_o = (state_q == FAULT);
    assign state_o       = state_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt_q;
    logic [31:0] perf_stall_cnt_q;
    logic        fetch_evt;

    assign fetch_evt = !stall_i && !flush_i && legal;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            perf_fetch_cnt_q <= 32'h0;
            perf_stall_cnt_q <= 32'h0;
        end else begin
            perf_fetch_cnt_q <= perf_fetch_cnt_q + {31'h0, fetch_evt};
            perf_stall_cnt_q <= perf_stall_cnt_q + {31'h0, stall_i};
        end
    end

    assign perf_fetch_cnt_o = perf_fetch_cnt_q;
    assign perf_stall_cnt_o = perf_stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: a cycle-level reference model compared every cycle,
// plus directed scenarios with literal expectations. Honors FETCH_PERF_CNT_EN.
module tb_fetch_ctrl;

    localparam logic [31:0]     PcInit  = 32'h0000_3000;
    localparam longint unsigned ImWords = 4096;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirectValid = 1'b0;
    logic [31:0] redirectTarget = 32'h0;
    logic [31:0] imAddr;
    logic [31:0] imInstr;
    logic [31:0] ifPc;
    logic [31:0] ifInstr;
    logic        ifValid;
    logic        fetchFault;
    logic [1:0]  state;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perfFetchCnt;
    logic [31:0] perfStallCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .stall_i           (stall),
        .flush_i           (flush),
        .redirect_valid_i  (redirectValid),
        .redirect_target_i (redirectTarget),
        .im_addr_o         (imAddr),
        .im_instr_i        (imInstr),
        .if_pc_o           (ifPc),
        .if_instr_o        (ifInstr),
        .if_valid_o        (ifValid),
        .fetch_fault_o     (fetchFault),
        .state_o           (state)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt_o  (perfFetchCnt),
        .perf_stall_cnt_o  (perfStallCnt)
`endif
    );

    // Instruction memory contents: 0xA/0xB/0xC at the first three words, address-derived elsewhere.
    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == 32'h3000) return 32'h0000_000A;
        if (addr == 32'h3004) return 32'h0000_000B;
        if (addr == 32'h3008) return 32'h0000_000C;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    always_comb imInstr = memWord(imAddr);

    function automatic bit isLegal(input logic [31:0] pc);
        longint unsigned p;
        p = longint'(pc);
        return (p % 4 == 0) && (p >= longint'(PcInit)) && (p < longint'(PcInit) + 4 * ImWords);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model state
    logic [31:0] mPc = PcInit;
    logic [31:0] mIfPc = PcInit;
    logic [31:0] mIfInstr = 32'h0;
    logic        mIfValid = 1'b0;
    logic        mFault = 1'b0;
    logic        mStalled = 1'b0;
    logic [31:0] mFetchCnt = 32'h0;
    logic [31:0] mStallCnt = 32'h0;

    always @(posedge clk) begin
        if (reset) begin
            mPc = PcInit; mIfPc = PcInit; mIfInstr = 32'h0; mIfValid = 1'b0;
            mFault = 1'b0; mStalled = 1'b0; mFetchCnt = 32'h0; mStallCnt = 32'h0;
        end else if (stall) begin
            mStalled = 1'b1;
            mStallCnt = mStallCnt + 32'd1;
        end else begin
            bit legal;
            legal = isLegal(mPc);
            mStalled = 1'b0;
            mIfPc = mPc;
            if (flush || !legal) begin
                mIfInstr = 32'h0; mIfValid = 1'b0;
            end else begin
                mIfInstr = memWord(mPc); mIfValid = 1'b1;
                mFetchCnt = mFetchCnt + 32'd1;
            end
            if (mFault) begin
                if (redirectValid) begin
                    mPc = redirectTarget; mFault = 1'b0;
                end
            end else if (!legal) begin
                mFault = 1'b1;
                if (redirectValid) mPc = redirectTarget;
            end else begin
                mPc = redirectValid ? redirectTarget : mPc + 32'd4;
            end
        end
        #1;
        checkOutput("im_addr", imAddr, mPc);
        checkOutput("if_pc", ifPc, mIfPc);
        checkOutput("if_instr", ifInstr, mIfInstr);
        checkOutput("if_valid", 32'(ifValid), 32'(mIfValid));
        checkOutput("fetch_fault", 32'(fetchFault), 32'(mFault));
        checkOutput("state", 32'(state), mFault ? 32'd2 : (mStalled ? 32'd1 : 32'd0));
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch_cnt", perfFetchCnt, mFetchCnt);
        checkOutput("perf_stall_cnt", perfStallCnt, mStallCnt);
`endif
    end

    // Drive one cycle of inputs and return after the next rising edge has been checked.
    task automatic applyStimulus(input logic s, input logic f, input logic rv, input logic [31:0] tgt);
        stall = s; flush = f; redirectValid = rv; redirectTarget = tgt;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("rst_im_addr", imAddr, 32'h3000);
        checkOutput("rst_if_pc", ifPc, 32'h3000);
        checkOutput("rst_if_valid", 32'(ifValid), 32'h0);
        checkOutput("rst_state", 32'(state), 32'h0);
        reset = 1'b0;

        applyStimulus(0, 0, 0, 0);
        checkOutput("run1_if_instr", ifInstr, 32'hA);
        checkOutput("run1_if_valid", 32'(ifValid), 32'h1);
        checkOutput("run1_im_addr", imAddr, 32'h3004);
        applyStimulus(0, 0, 0, 0);
        checkOutput("run2_if_instr", ifInstr, 32'hB);
        checkOutput("run2_im_addr", imAddr, 32'h3008);

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("stall_im_addr", imAddr, 32'h3008);
        checkOutput("stall_if_pc", ifPc, 32'h3004);
        checkOutput("stall_state", 32'(state), 32'h1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("unstall_if_instr", ifInstr, 32'hC);
        checkOutput("unstall_im_addr", imAddr, 32'h300C);
        applyStimulus(0, 0, 0, 0);

        applyStimulus(0, 0, 1, 32'h3100);
        checkOutput("slot_if_pc", ifPc, 32'h3010);
        checkOutput("slot_if_valid", 32'(ifValid), 32'h1);
        checkOutput("redir_im_addr", imAddr, 32'h3100);
        checkOutput("model_pc_redir", mPc, 32'h3100);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 1, 32'h3200);
        checkOutput("flush_if_pc", ifPc, 32'h3104);
        checkOutput("flush_if_valid", 32'(ifValid), 32'h0);
        checkOutput("flush_if_instr", ifInstr, 32'h0);
        checkOutput("flush_im_addr", imAddr, 32'h3200);

        applyStimulus(0, 0, 1, 32'h3002);
        applyStimulus(0, 0, 0, 0);
        checkOutput("mis_fault", 32'(fetchFault), 32'h1);
        checkOutput("mis_state", 32'(state), 32'h2);
        checkOutput("mis_if_valid", 32'(ifValid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("mis_hold_addr", imAddr, 32'h3002);
        end
        applyStimulus(1, 0, 0, 0);
        checkOutput("fault_stall_state", 32'(state), 32'h2);
        applyStimulus(1, 0, 1, 32'h3000);
        checkOutput("fault_stall_redir_ignored", imAddr, 32'h3002);
        applyStimulus(0, 0, 1, 32'h3000);
        checkOutput("recover_fault", 32'(fetchFault), 32'h0);
        checkOutput("recover_state", 32'(state), 32'h0);
        checkOutput("recover_im_addr", imAddr, 32'h3000);
        applyStimulus(0, 0, 0, 0);
        checkOutput("recover_if_instr", ifInstr, 32'hA);
        checkOutput("recover_if_valid", 32'(ifValid), 32'h1);

        applyStimulus(0, 0, 1, 32'h6FF8);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("last_if_pc", ifPc, 32'h6FFC);
        checkOutput("last_if_instr", ifInstr, 32'h6FFC_9003);
        checkOutput("last_if_valid", 32'(ifValid), 32'h1);
        checkOutput("last_fault", 32'(fetchFault), 32'h0);
        checkOutput("model_last_instr", mIfInstr, 32'h6FFC_9003);
        applyStimulus(0, 0, 0, 0);
        checkOutput("end_fault", 32'(fetchFault), 32'h1);
        checkOutput("end_im_addr", imAddr, 32'h7000);

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset = 1'b0;
        checkOutput("rst2_im_addr", imAddr, 32'h3000);
        checkOutput("rst2_fault", 32'(fetchFault), 32'h0);
        checkOutput("rst2_if_instr", ifInstr, 32'h0);
        checkOutput("rst2_state", 32'(state), 32'h0);

        applyStimulus(0, 0, 1, 32'h2FFC);
        applyStimulus(0, 0, 0, 0);
        checkOutput("below_fault", 32'(fetchFault), 32'h1);
        checkOutput("below_im_addr", imAddr, 32'h2FFC);

        reset = 1'b1;
        applyStimulus(0, 0, 0, 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("perf_im_addr", imAddr, 32'h301C);
        checkOutput("model_fetch_cnt", mFetchCnt, 32'd6);
        checkOutput("model_stall_cnt", mStallCnt, 32'd3);
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_fetch_total", perfFetchCnt, 32'd6);
        checkOutput("perf_stall_total", perfStallCnt, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the pipelined MIPS core; owns the PC register and drives the address of the asynchronous-read instruction memory.
- Registers fetched words into the F/D pipeline register.
- Handles stall, branch/jump redirect, F/D flush and out-of-range/misaligned fetch detection, which places the block in a FAULT state.

Parameters:
- PC_INIT, 32'h0000_3000, reset PC and base address of instruction memory.
- IM_WORDS, 4096, instruction memory depth in 32-bit words; legal range is [PC_INIT, PC_INIT + 4*IM_WORDS).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- stall, input, 1, from hazard unit; freeze PC and F/D.
- flush, input, 1, clear F/D to a bubble; PC still advances or redirects.
- redirect_valid, input, 1, branch/jump resolved in D; load redirect_target.
- redirect_target, input, 32, new PC.
- im_addr, output, 32, address to instruction memory; combinational, equals pc_q.
- im_instr, input, 32, instruction word returned the same cycle.
- if_pc, output, 32, F/D register: PC of the held instruction.
- if_instr, output, 32, F/D register: instruction word; 0 (nop) when invalid.
- if_valid, output, 1, F/D register holds a real instruction.
- fetch_fault, output, 1, sticky; current PC is illegal.
- state, output, 2, 0 = RUN, 1 = STALL, 2 = FAULT; for debug.

Behaviour:
- Reset: pc_q = PC_INIT, if_pc = PC_INIT, if_instr = 0, if_valid = 0, fetch_fault = 0, state = RUN.
- Reset mid-operation overrides every other input in that cycle.
- Legality check, combinational: legal = (pc_q[1:0] == 0) and PC_INIT <= pc_q < PC_INIT + 4*IM_WORDS. Compare as unsigned 32-bit, with no wrap.
- Per-cycle priority: reset > stall > redirect > sequential advance. flush is evaluated independently for F/D.
- stall = 1:
  - pc_q, if_pc, if_instr, if_valid and fetch_fault hold; state = STALL.
  - flush and redirect_valid are ignored, so the requester must hold them until stall drops.
- stall = 0, redirect_valid = 1: pc_q <= redirect_target.
- stall = 0, redirect_valid = 0: pc_q <= pc_q + 4 (32-bit wrap), except in FAULT, where pc_q holds.
- F/D capture when stall = 0:
  - if_pc <= pc_q.
  - If flush or !legal, then if_instr <= 0 and if_valid <= 0.
  - Otherwise if_instr <= im_instr and if_valid <= 1.
- Delay slot: on a redirect cycle, the word at the current pc_q is still captured (branch delay slot), unless flush is also asserted.
- Latency: PC to F/D is 1 cycle. A redirect takes effect on im_addr the cycle after redirect_valid.
- State transitions:
  - RUN → STALL on stall. STALL → RUN when stall drops.
  - RUN → FAULT when stall = 0 and !legal. In that cycle fetch_fault <= 1 and a bubble is captured.
  - FAULT: im_addr still drives pc_q; no sequential advance; bubbles are captured every cycle.
  - FAULT → RUN only via redirect_valid with stall = 0. fetch_fault clears the same edge; legality of the new target is checked next cycle.
  - FAULT with stall: remains FAULT. The state output reports FAULT, which has priority over STALL.
- Last legal word (PC_INIT + 4*IM_WORDS - 4) is fetched normally. The next PC is illegal, giving FAULT one cycle later.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0 and wrapping at 2^32:
  - perf_fetch_cnt increments on each cycle in which if_valid is written to 1.
  - perf_stall_cnt increments on each stall = 1 cycle.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then 3 free-running cycles with IM words 0xA, 0xB, 0xC at 0x3000/0x3004/0x3008 → im_addr 0x3000, 0x3004, 0x3008, 0x300C; if_pc/if_instr 0x3000/0xA … 0x3008/0xC; if_valid = 1 from cycle 1.
- stall held for 2 cycles at pc_q = 0x3008 → im_addr stays 0x3008, F/D unchanged, state = 1; on release, pc advances to 0x300C.
- redirect_valid with target 0x3100 at pc_q = 0x3010 → F/D captures 0x3010 (delay slot), next im_addr 0x3100. Same with flush = 1 → captured word is a bubble (if_valid 0, if_instr 0).
- redirect to 0x3002 → next cycle fetch_fault = 1, state = 2, if_valid 0, im_addr holds 0x3002 for 5 cycles; redirect to 0x3000 → fetch_fault 0, state 0, 0x3000 fetched the following cycle.
- Run to 0x6FFC with IM_WORDS = 4096 → 0x6FFC fetched valid; pc 0x7000 raises fault. Assert reset during FAULT → all outputs back to reset values.
- With FETCH_PERF_CNT_EN: 10 fetch cycles including 3 stall cycles and 1 flush → perf_stall_cnt = 3, perf_fetch_cnt = 6.
